// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit with a req/ack data port, lane formatting and a watchdog.
// Define MISALIGN_TRAP_EN to trap misaligned H/HU/W accesses instead of issuing them to memory.
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_alu_dataM,
    input  logic [31:0] i_rs2_dataM,
    input  logic [2:0]  i_lsu_opM,
    input  logic        i_mem_rdM,
    input  logic        i_mem_wrM,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic [31:0] o_ld_dataM,
    output logic        o_stallM,
    output logic        o_errM,
    output logic        o_misalignM
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    lane;
    logic [2:0]    op_q;
    logic          access;
    logic          trap;

    // Access size: 0 = byte, 1 = half, 2 = word (undefined funct3 behaves as word).
    function automatic logic [1:0] size_of(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: size_of = 2'd0;
            3'b001, 3'b101: size_of = 2'd1;
            default:        size_of = 2'd2;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] op, input logic [1:0] a);
        case (size_of(op))
            2'd0:    store_be = 4'b0001 << a;
            2'd1:    store_be = a[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] d);
        case (size_of(op))
            2'd0:    store_data = {4{d[7:0]}};
            2'd1:    store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] rdata);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rdata[{a, 3'b000} +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            3'b000:  load_fmt = 32'(b);
            3'b001:  load_fmt = 32'(h);
            3'b100:  load_fmt = {24'b0, b};
            3'b101:  load_fmt = {16'b0, h};
            default: load_fmt = rdata;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        case (size_of(op))
            2'd1:    misaligned = a[0];
            2'd2:    misaligned = (a != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    assign trap = misaligned(i_lsu_opM, i_alu_dataM[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign access = i_mem_rdM | i_mem_wrM;

    // Gated by reset so the pipeline is released the moment reset asserts.
    assign o_stallM = i_rst_n & (((state == IDLE) & access) | (state == BUSY));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            lane         <= 2'b00;
            op_q         <= 3'b000;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= 32'b0;
            o_dmem_wdata <= 32'b0;
            o_dmem_be    <= 4'b0;
            o_ld_dataM   <= 32'b0;
            o_errM       <= 1'b0;
            o_misalignM  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (access) begin
                        op_q <= i_lsu_opM;
                        lane <= i_alu_dataM[1:0];
                        if (trap) begin
                            o_misalignM <= 1'b1;
                            if (!i_mem_wrM) o_ld_dataM <= 32'b0;
                            state <= DONE;
                        end else begin
                            o_dmem_req   <= 1'b1;
                            o_dmem_we    <= i_mem_wrM;
                            o_dmem_addr  <= {i_alu_dataM[31:2], 2'b00};
                            o_dmem_be    <= i_mem_wrM ? store_be(i_lsu_opM, i_alu_dataM[1:0])
                                                      : 4'b1111;
                            o_dmem_wdata <= store_data(i_lsu_opM, i_rs2_dataM);
                            state        <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // An ack on the final watchdog cycle still completes normally.
                    if (i_dmem_ack) begin
                        o_dmem_req <= 1'b0;
                        if (!o_dmem_we) o_ld_dataM <= load_fmt(op_q, lane, i_dmem_rdata);
                        state <= DONE;
                    end else if ((TIMEOUT > 0) && (cnt == CNT_LAST)) begin
                        o_dmem_req <= 1'b0;
                        if (!o_dmem_we) o_ld_dataM <= 32'b0;
                        o_errM <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    o_errM      <= 1'b0;
                    o_misalignM <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: byte-level reference memory, randomized loads/stores and ack latencies.
module tb_mem_lsu;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] BASE    = 32'h100;
    localparam int          NO_ACK  = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_data = '0;
    logic [31:0] rs2_data = '0;
    logic [2:0]  lsu_op = '0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [31:0] ld_data;
    logic        stall;
    logic        err;
    logic        misalign;

    mem_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_alu_dataM(alu_data), .i_rs2_dataM(rs2_data), .i_lsu_opM(lsu_op),
        .i_mem_rdM(mem_rd), .i_mem_wrM(mem_wr),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
        .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
        .o_ld_dataM(ld_data), .o_stallM(stall), .o_errM(err), .o_misalignM(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        issue;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        err;
        logic        mis;
        int          stall;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  ref_mem[0:63];
    logic [31:0] dmem[0:15];
    logic [31:0] last_ld = '0;
    int          ack_delay = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay extra BUSY cycles, writes honour byte enables.
    int wcnt = 0;
    always @(negedge clk) begin : responder
        logic [3:0] widx;
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        if (dmem_req) begin
            if (wcnt == ack_delay) begin
                widx       = dmem_addr[5:2];
                dmem_ack   = 1'b1;
                dmem_rdata = dmem[widx];
                if (dmem_we)
                    for (int i = 0; i < 4; i++)
                        if (dmem_be[i]) dmem[widx][8*i +: 8] = dmem_wdata[8*i +: 8];
            end
            wcnt++;
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: captures the request, pops the scoreboard in the cycle the stall releases.
    int          stall_cnt = 0;
    logic        prev_stall = 1'b0;
    logic        seen_req = 1'b0;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            stall_cnt  = 0;
            prev_stall = 1'b0;
            seen_req   = 1'b0;
        end else begin
            if (dmem_req && !seen_req) begin
                seen_req = 1'b1;
                r_we = dmem_we; r_addr = dmem_addr; r_wdata = dmem_wdata; r_be = dmem_be;
            end
            if (stall) begin
                stall_cnt++;
            end else if (prev_stall) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: got completion expected none");
                end else begin
                    e = sb.pop_front();
                    check("issued", 32'(seen_req), 32'(e.issue));
                    if (e.issue) begin
                        check("we", 32'(r_we), 32'(e.we));
                        check("addr", r_addr, e.addr);
                        check("be", 32'(r_be), 32'(e.be));
                        if (e.we) check("wdata", r_wdata, e.wdata);
                    end
                    check("ld_data", ld_data, e.ld);
                    check("err", 32'(err), 32'(e.err));
                    check("misalign", 32'(misalign), 32'(e.mis));
                    check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                end
                stall_cnt = 0;
                seen_req  = 1'b0;
            end
            prev_stall = stall;
        end
    end

    // Builds the expectation from the byte-level memory view, then drives one access.
    task automatic access(input logic wr, input logic both, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] d, input int dly);
        exp_t        e;
        int          size;
        int          idx;
        logic [31:0] eff;
        logic        trap;
        logic        tmo;
        logic        done;
        logic [63:0] v;
        size = (op == 3'b000 || op == 3'b100) ? 1 : (op == 3'b001 || op == 3'b101) ? 2 : 4;
        eff  = a & ~32'(size - 1);
`ifdef MISALIGN_TRAP_EN
        trap = (eff != a);
`else
        trap = 1'b0;
`endif
        tmo     = !trap && (dly >= TIMEOUT);
        e.issue = !trap;
        e.we    = wr;
        e.addr  = {a[31:2], 2'b00};
        e.be    = wr ? 4'(((1 << size) - 1) << eff[1:0]) : 4'hF;
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = d[8*(i % size) +: 8];
        e.err   = tmo;
        e.mis   = trap;
        e.stall = trap ? 1 : (tmo ? 1 + TIMEOUT : dly + 2);
        idx     = int'(eff - BASE);
        if (!wr) begin
            if (trap || tmo) begin
                last_ld = '0;
            end else begin
                v = '0;
                for (int i = 0; i < size; i++) v |= 64'(ref_mem[6'(idx + i)]) << (8 * i);
                if ((op == 3'b000 || op == 3'b001) && v[8*size-1]) v |= ~((64'd1 << (8 * size)) - 1);
                last_ld = v[31:0];
            end
        end else if (!trap && !tmo) begin
            for (int i = 0; i < size; i++) ref_mem[6'(idx + i)] = d[8*i +: 8];
        end
        e.ld = last_ld;
        sb.push_back(e);

        ack_delay = dly;
        mem_wr = wr; mem_rd = both | !wr; lsu_op = op; alu_data = a; rs2_data = d;
        done = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL completion_wait: got no stall release expected within 64 cycles");
        end
        mem_rd = 1'b0; mem_wr = 1'b0; alu_data = $urandom; rs2_data = $urandom;
        repeat (1 + $urandom_range(0, 2)) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [2:0]  op;
        logic        wr;
        int          dly;
        logic [31:0] a;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
        for (int w = 0; w < 16; w++)
            dmem[w] = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};

        // Reset state with a load request already presented.
        mem_rd = 1'b1;
        #3;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_ld", ld_data, 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mis", 32'(misalign), 32'd0);
        mem_rd = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        access(1'b1, 1'b0, 3'b010, BASE + 32'h4, 32'hDEADBEEF, 0);
        access(1'b1, 1'b0, 3'b010, BASE, 32'h80FF0000, 0);
        access(1'b0, 1'b0, 3'b000, BASE + 32'h3, 32'h0, 3);
        access(1'b0, 1'b0, 3'b100, BASE + 32'h3, 32'h0, 3);
        access(1'b1, 1'b0, 3'b001, BASE + 32'h2, 32'h1234ABCD, 1);
        access(1'b0, 1'b0, 3'b010, BASE + 32'h8, 32'h0, NO_ACK);
        access(1'b0, 1'b0, 3'b010, BASE + 32'h8, 32'h0, TIMEOUT - 1);
        access(1'b0, 1'b0, 3'b010, BASE + 32'h2, 32'h0, 0);
        access(1'b1, 1'b1, 3'b000, BASE + 32'h9, 32'h000000A5, 2);
        access(1'b0, 1'b0, 3'b101, BASE + 32'h3, 32'h0, 0);

        // Reset asserted while an access is outstanding.
        ack_delay = NO_ACK;
        mem_rd = 1'b1; lsu_op = 3'b010; alu_data = BASE + 32'hC;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req", 32'(dmem_req), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_be", 32'(dmem_be), 32'd0);
        check("midrst_ld", ld_data, 32'd0);
        last_ld = '0;
        mem_rd = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #2;
        access(1'b0, 1'b0, 3'b010, BASE + 32'h4, 32'h0, 0);

        for (int n = 0; n < 200; n++) begin
            wr = 1'($urandom_range(0, 1));
            if (wr) begin
                case ($urandom_range(0, 5))
                    0, 1: op = 3'b000;
                    2, 3: op = 3'b001;
                    4:    op = 3'b010;
                    default: op = 3'($urandom_range(0, 2) == 0 ? 3 : ($urandom_range(0, 1) ? 6 : 7));
                endcase
            end else begin
                op = 3'($urandom_range(0, 7));
            end
            a = BASE + 32'($urandom_range(0, 63));
            case ($urandom_range(0, 19))
                0:       dly = wr ? 1 : NO_ACK;
                1:       dly = TIMEOUT - 1;
                default: dly = $urandom_range(0, 5);
            endcase
            access(wr, 1'($urandom_range(0, 7) == 0), op, a, $urandom, dly);
        end

        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
